// File: rtl/dot_pkg.sv
// Types and constants shared by the weight loader and the dot-product engine.
// The weight-array typedef is sized for the default matrix shape.
package dot_pkg;

  localparam int WORD_W   = 32;
  localparam int ROWS_DEF = 3;
  localparam int COLS_DEF = 4;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef logic [0:ROWS_DEF-1][0:COLS_DEF-1][WORD_W-1:0] weight_arr_t;

endpackage

// File: rtl/weight_loader.sv
// Streams a row-major weight matrix into a shadow buffer, checks its length
// against TLAST, and swaps it into the active array when the engine is idle.
module weight_loader
  import dot_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [WORD_W-1:0]                       WEIGHT_AXIS_TDATA,
  input  logic                                    WEIGHT_AXIS_TLAST,
  input  logic                                    WEIGHT_AXIS_TVALID,
  output logic                                    WEIGHT_AXIS_TREADY,
  input  logic                                    swap_hold,
  output logic [0:ROWS-1][0:COLS-1][WORD_W-1:0]   weights,
  output logic                                    weights_valid,
  output logic                                    load_done,
  output logic                                    frame_err
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  state_t                                  state;
  state_t                                  state_nxt;
  logic [RW-1:0]                           row;
  logic [RW-1:0]                           row_nxt;
  logic [CW-1:0]                           col;
  logic [CW-1:0]                           col_nxt;
  logic [0:ROWS-1][0:COLS-1][WORD_W-1:0]   shadow;
  logic                                    xfer;
  logic                                    last_slot;
  logic                                    store;
  logic                                    commit;
  logic                                    err_nxt;

  // Ready depends on state only, so the shadow cannot move during a held commit.
  always_comb begin
    WEIGHT_AXIS_TREADY = rst && (state != ST_COMMIT);
  end

  // Next-state, counter and strobe decode.
  always_comb begin
    xfer      = WEIGHT_AXIS_TVALID && WEIGHT_AXIS_TREADY;
    last_slot = (row == ROW_LAST) && (col == COL_LAST);
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    store     = 1'b0;
    commit    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_LOAD: begin
        if (xfer) begin
          store = 1'b1;
          if (last_slot) begin
            row_nxt = '0;
            col_nxt = '0;
            if (WEIGHT_AXIS_TLAST) begin
              state_nxt = ST_COMMIT;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = ST_DRAIN;
            end
          end else if (WEIGHT_AXIS_TLAST) begin
            err_nxt = 1'b1;
            row_nxt = '0;
            col_nxt = '0;
          end else if (col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = row + RW'(1);
          end else begin
            col_nxt = col + CW'(1);
          end
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (xfer && WEIGHT_AXIS_TLAST) begin
          state_nxt = ST_LOAD;
          row_nxt   = '0;
          col_nxt   = '0;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_COMMIT: begin
        if (!swap_hold) begin
          commit    = 1'b1;
          state_nxt = ST_LOAD;
          row_nxt   = '0;
          col_nxt   = '0;
        end else begin
          state_nxt = ST_COMMIT;
        end
      end
      default: begin
        state_nxt = ST_LOAD;
        row_nxt   = '0;
        col_nxt   = '0;
      end
    endcase
  end

  // State, counters, shadow/active arrays and registered status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_LOAD;
      row           <= '0;
      col           <= '0;
      shadow        <= '0;
      weights       <= '0;
      weights_valid <= 1'b0;
      load_done     <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      if (store) begin
        shadow[row][col] <= WEIGHT_AXIS_TDATA;
      end
      if (commit) begin
        weights       <= shadow;
        weights_valid <= 1'b1;
      end
      load_done <= commit;
      frame_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: frame-level reference model compared every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_weight_loader;
  import dot_pkg::*;

  localparam int R = 3;
  localparam int C = 4;
  localparam int N = R * C;
  localparam int WA = N * 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] tdata = 32'd0;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        swap_hold = 1'b0;
  weight_arr_t weights;
  logic        weights_valid;
  logic        load_done;
  logic        frame_err;

  weight_loader #(.ROWS(R), .COLS(C)) dut (
    .clk                (clk),
    .rst                (rst),
    .WEIGHT_AXIS_TDATA  (tdata),
    .WEIGHT_AXIS_TLAST  (tlast),
    .WEIGHT_AXIS_TVALID (tvalid),
    .WEIGHT_AXIS_TREADY (tready),
    .swap_hold          (swap_hold),
    .weights            (weights),
    .weights_valid      (weights_valid),
    .load_done          (load_done),
    .frame_err          (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [WA-1:0] got, input logic [WA-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: whole-frame view (collected words, drain flag, pending commit).
  int unsigned q[$];
  bit          m_on = 1'b0;
  bit          m_drain = 1'b0;
  bit          m_pend = 1'b0;
  weight_arr_t m_shadow = '0;
  weight_arr_t m_w = '0;
  bit          m_valid = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;

  initial forever begin
    @(posedge clk);
    m_on = 1'b1;
    if (!rst) begin
      q.delete();
      m_drain = 0; m_pend = 0; m_w = '0; m_valid = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_pend) begin
        if (!swap_hold) begin
          m_w = m_shadow; m_valid = 1; m_done = 1; m_pend = 0;
        end
      end else if (tvalid) begin
        if (m_drain) begin
          if (tlast) m_drain = 0;
        end else begin
          q.push_back(tdata);
          if (q.size() == N) begin
            if (tlast) begin
              for (int k = 0; k < N; k++) m_shadow[k / C][k % C] = q[k];
              m_pend = 1;
            end else begin
              m_err = 1; m_drain = 1;
            end
            q.delete();
          end else if (tlast) begin
            m_err = 1;
            q.delete();
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    #1;
    if (m_on) begin
      chk("weights", weights, m_w);
      chk("weights_valid", WA'(weights_valid), WA'(m_valid));
      chk("load_done", WA'(load_done), WA'(m_done));
      chk("frame_err", WA'(frame_err), WA'(m_err));
      chk("tready", WA'(tready), WA'(rst && !m_pend));
      if (load_done === 1'b1) done_cnt++;
    end
  end

  // Offer one word and return at the negedge after it has been accepted.
  task automatic send(input logic [31:0] d, input logic l);
    bit ok = 0;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (tready) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    if (!ok) chk("tready_timeout", WA'(0), WA'(1));
  endtask

  task automatic frame(input int base, input int len, input int max_gap);
    for (int k = 1; k <= len; k++) begin
      send(32'(base + k), k == len);
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_weights", weights, WA'(0));
    chk("reset_valid", WA'(weights_valid), WA'(0));
    chk("reset_tready", WA'(tready), WA'(0));
    rst = 1'b1;
    @(negedge clk);

    // Nominal load 1..12
    frame(0, N, 0);
    @(negedge clk); #1;
    chk("nom_done", WA'(load_done), WA'(1));
    chk("nom_w00", WA'(weights[0][0]), WA'(32'd1));
    chk("nom_w10", WA'(weights[1][0]), WA'(32'd5));
    chk("nom_w23", WA'(weights[2][3]), WA'(32'd12));
    chk("nom_valid", WA'(weights_valid), WA'(1));
    @(negedge clk); #1;
    chk("nom_done_once", WA'(load_done), WA'(0));

    // Short frame after a reset, then a good frame
    pulse_reset();
    frame(0, 5, 0);
    #1;
    chk("short_err", WA'(frame_err), WA'(1));
    chk("short_w", weights, WA'(0));
    chk("short_valid", WA'(weights_valid), WA'(0));
    frame(20, N, 0);
    repeat (2) @(negedge clk); #1;
    chk("after_short_w00", WA'(weights[0][0]), WA'(32'd21));

    // Long frame: 14 words
    done_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      send(32'(40 + k), k == 14);
      if (k == 12) begin
        #1;
        chk("long_err", WA'(frame_err), WA'(1));
      end
    end
    repeat (3) @(negedge clk); #1;
    chk("long_no_done", WA'(done_cnt), WA'(0));
    chk("long_w00", WA'(weights[0][0]), WA'(32'd21));
    chk("long_w23", WA'(weights[2][3]), WA'(32'd32));

    // Held commit
    swap_hold = 1'b1;
    for (int k = 1; k <= N; k++) send(32'h3F80_0000, k == N);
    repeat (20) @(negedge clk);
    #1;
    chk("hold_tready", WA'(tready), WA'(0));
    chk("hold_w00", WA'(weights[0][0]), WA'(32'd21));
    done_cnt = 0;
    swap_hold = 1'b0;
    @(negedge clk); #1;
    chk("hold_done", WA'(load_done), WA'(1));
    for (int k = 0; k < N; k++)
      chk("hold_w", WA'(weights[k / C][k % C]), WA'(32'h3F80_0000));
    @(negedge clk); #1;
    chk("hold_done_once", WA'(done_cnt), WA'(1));

    // Back-to-back with random gaps
    done_cnt = 0;
    frame(0, N, 3);
    repeat (3) @(negedge clk); #1;
    chk("b2b_a_w23", WA'(weights[2][3]), WA'(32'd12));
    frame(100, N, 3);
    repeat (3) @(negedge clk); #1;
    chk("b2b_b_w00", WA'(weights[0][0]), WA'(32'd101));
    chk("b2b_b_w23", WA'(weights[2][3]), WA'(32'd112));
    chk("b2b_pulses", WA'(done_cnt), WA'(2));

    // Reset mid-frame
    frame(0, 6, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_w", weights, WA'(0));
    chk("mid_rst_valid", WA'(weights_valid), WA'(0));
    frame(200, N, 0);
    repeat (2) @(negedge clk); #1;
    chk("mid_rst_w00", WA'(weights[0][0]), WA'(32'd201));
    chk("mid_rst_w23", WA'(weights[2][3]), WA'(32'd212));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
